// File: rtl/l1i_pkg.sv
// Shared widths, refill geometry and FSM states for the L1I refill path.
package l1i_pkg;

  localparam int defaultAddressWidth   = 64;
  localparam int defaultLineWidth      = 512;
  localparam int defaultBeatWidth      = 256;
  localparam int defaultPidSize        = 20;
  localparam int defaultTidSize        = 16;
  localparam int defaultMissQueueDepth = 2;

  // One refill fetches a 128-byte block: two 64-byte lines in four beats.
  localparam int refillBeats      = 4;
  localparam int blockOffsetWidth = 7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    UPDATE
  } refillState_t;

endpackage

// File: rtl/l1i_miss_queue.sv
// Small shift-style FIFO of pending misses {block address, Pid, Tid}
// with a combinational "already queued" match against a probe.
module l1i_miss_queue
  import l1i_pkg::*;
#(
  parameter int addrWidth = defaultAddressWidth,
  parameter int pidSize   = defaultPidSize,
  parameter int tidSize   = defaultTidSize,
  parameter int depth     = defaultMissQueueDepth
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 push,
  input  logic [addrWidth-1:0] pushAddress,
  input  logic [pidSize-1:0]   pushPid,
  input  logic [tidSize-1:0]   pushTid,
  input  logic                 pop,
  input  logic                 flush,
  output logic [addrWidth-1:0] headAddress,
  output logic [pidSize-1:0]   headPid,
  output logic [tidSize-1:0]   headTid,
  output logic                 empty,
  output logic                 full,
  input  logic [addrWidth-1:0] matchAddress,
  input  logic [pidSize-1:0]   matchPid,
  output logic                 match
);

  localparam int countWidth = $clog2(depth + 1);
  localparam logic [countWidth-1:0] depthCount = countWidth'(depth);

  logic [addrWidth-1:0]  addrMem [depth];
  logic [pidSize-1:0]    pidMem  [depth];
  logic [tidSize-1:0]    tidMem  [depth];
  logic [countWidth-1:0] count;
  logic [countWidth-1:0] countNext;
  logic [countWidth-1:0] writeIndex;
  logic                  fullReg;

  always_comb begin
    countNext = count;
    if (flush) begin
      countNext = '0;
    end else if (push && !pop) begin
      countNext = count + 1'b1;
    end else if (pop && !push) begin
      countNext = count - 1'b1;
    end
  end

  assign writeIndex = pop ? count - 1'b1 : count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      fullReg <= 1'b0;
    end else begin
      count   <= countNext;
      fullReg <= (countNext == depthCount);
    end
  end

  // Entry 0 is always the head; a pop shifts everything down and a
  // simultaneous push lands in the slot freed at the tail.
  always_ff @(posedge clock) begin
    if (pop) begin
      for (int i = 0; i < depth - 1; i++) begin
        addrMem[i] <= addrMem[i+1];
        pidMem[i]  <= pidMem[i+1];
        tidMem[i]  <= tidMem[i+1];
      end
    end
    if (push && !flush) begin
      for (int i = 0; i < depth; i++) begin
        if (i == int'(writeIndex)) begin
          addrMem[i] <= pushAddress;
          pidMem[i]  <= pushPid;
          tidMem[i]  <= pushTid;
        end
      end
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < depth; i++) begin
      if (i < int'(count) && addrMem[i] == matchAddress && pidMem[i] == matchPid) begin
        match = 1'b1;
      end
    end
  end

  assign headAddress = addrMem[0];
  assign headPid     = pidMem[0];
  assign headTid     = tidMem[0];
  assign empty       = (count == '0);
  assign full        = fullReg;

endmodule

// File: rtl/l1i_refill_controller.sv
// L1I refill controller: queues instruction-cache misses, requests 128-byte
// blocks from memory and writes both 64-byte lines back in one update.
module l1i_refill_controller
  import l1i_pkg::*;
#(
  parameter int fetchingAddressWidth = defaultAddressWidth,
  parameter int cacheLineWidth       = defaultLineWidth,
  parameter int memBeatWidth         = defaultBeatWidth,
  parameter int PidSize              = defaultPidSize,
  parameter int TidSize              = defaultTidSize,
  parameter int missQueueDepth       = defaultMissQueueDepth
) (
  input  logic                            clock_i,
  input  logic                            resetn_i,
  input  logic                            cacheMiss_i,
  input  logic [fetchingAddressWidth-1:0] missedAddress_i,
  input  logic [PidSize-1:0]              missedPid_i,
  input  logic [TidSize-1:0]              missedTid_i,
  input  logic                            flush_i,
  output logic                            memReqValid_o,
  input  logic                            memReqReady_i,
  output logic [fetchingAddressWidth-1:0] memReqAddress_o,
  input  logic                            memRespValid_i,
  input  logic [memBeatWidth-1:0]         memRespData_i,
  input  logic                            memRespError_i,
  output logic                            cacheUpdate_o,
  output logic [fetchingAddressWidth-1:0] cacheUpdateAddress_o,
  output logic [cacheLineWidth-1:0]       cacheUpdateLine1_o,
  output logic [cacheLineWidth-1:0]       cacheUpdateLine2_o,
  output logic [PidSize-1:0]              cacheUpdatePid_o,
  output logic [TidSize-1:0]              cacheUpdateTid_o,
  output logic                            missQueueFull_o,
  output logic                            refillError_o,
  output logic                            busy_o
);

  localparam int bufferWidth    = refillBeats * memBeatWidth;
  localparam int beatCountWidth = $clog2(refillBeats);
  localparam logic [fetchingAddressWidth-1:0] blockMask =
    ~fetchingAddressWidth'((1 << blockOffsetWidth) - 1);

  refillState_t state, stateNext;

  logic [fetchingAddressWidth-1:0] blockAddress;
  logic [fetchingAddressWidth-1:0] headAddress;
  logic [PidSize-1:0]              headPid;
  logic [TidSize-1:0]              headTid;
  logic                            queueEmpty;
  logic                            queueFull;
  logic                            queueMatch;
  logic                            inflightMatch;
  logic                            pushMiss;
  logic                            popHead;
  logic                            lastBeat;

  logic [fetchingAddressWidth-1:0] inflightAddress;
  logic [PidSize-1:0]              inflightPid;
  logic [TidSize-1:0]              inflightTid;
  logic [bufferWidth-1:0]          refillBuffer;
  logic [beatCountWidth-1:0]       beatCount;
  logic                            errorFlag;

  assign blockAddress  = missedAddress_i & blockMask;
  assign inflightMatch = (state != IDLE) && (inflightAddress == blockAddress)
                         && (inflightPid == missedPid_i);
  assign pushMiss      = cacheMiss_i && !flush_i && !queueMatch && !inflightMatch
                         && (!queueFull || popHead);
  assign lastBeat      = (beatCount == beatCountWidth'(refillBeats - 1));

  l1i_miss_queue #(
    .addrWidth (fetchingAddressWidth),
    .pidSize   (PidSize),
    .tidSize   (TidSize),
    .depth     (missQueueDepth)
  ) missQueue (
    .clock        (clock_i),
    .resetn       (resetn_i),
    .push         (pushMiss),
    .pushAddress  (blockAddress),
    .pushPid      (missedPid_i),
    .pushTid      (missedTid_i),
    .pop          (popHead),
    .flush        (flush_i),
    .headAddress  (headAddress),
    .headPid      (headPid),
    .headTid      (headTid),
    .empty        (queueEmpty),
    .full         (queueFull),
    .matchAddress (blockAddress),
    .matchPid     (missedPid_i),
    .match        (queueMatch)
  );

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // A flush in the same cycle as a pop wins: the head is discarded, not started.
  always_comb begin
    stateNext = state;
    popHead   = 1'b0;
    case (state)
      IDLE: begin
        if (!queueEmpty && !flush_i) begin
          popHead   = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (memReqReady_i) begin
          stateNext = FILL;
        end
      end
      FILL: begin
        if (memRespValid_i && lastBeat) begin
          stateNext = UPDATE;
        end
      end
      UPDATE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Beats land in order into one double-line buffer; the counter wraps to 0
  // on the last beat, so it is already cleared for the next refill.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      inflightAddress <= '0;
      inflightPid     <= '0;
      inflightTid     <= '0;
      refillBuffer    <= '0;
      beatCount       <= '0;
      errorFlag       <= 1'b0;
    end else begin
      if (popHead) begin
        inflightAddress <= headAddress;
        inflightPid     <= headPid;
        inflightTid     <= headTid;
        errorFlag       <= 1'b0;
      end
      if (state == FILL && memRespValid_i) begin
        refillBuffer[int'(beatCount) * memBeatWidth +: memBeatWidth] <= memRespData_i;
        beatCount <= beatCount + 1'b1;
        if (memRespError_i) begin
          errorFlag <= 1'b1;
        end
      end
    end
  end

  assign memReqValid_o        = (state == REQ);
  assign memReqAddress_o      = inflightAddress;
  assign cacheUpdate_o        = (state == UPDATE) && !errorFlag;
  assign refillError_o        = (state == UPDATE) && errorFlag;
  assign cacheUpdateAddress_o = inflightAddress;
  assign cacheUpdateLine1_o   = refillBuffer[cacheLineWidth-1:0];
  assign cacheUpdateLine2_o   = refillBuffer[bufferWidth-1:cacheLineWidth];
  assign cacheUpdatePid_o     = inflightPid;
  assign cacheUpdateTid_o     = inflightTid;
  assign missQueueFull_o      = queueFull;
  assign busy_o               = (state != IDLE) || !queueEmpty;

endmodule

// File: tb/tb_l1i_refill_controller.sv
// Scoreboard bench for l1i_refill_controller: directed misses and beats push
// expected requests/updates; a negedge monitor pops and compares them.
module tb_l1i_refill_controller;

  logic         clock_i = 1'b0;
  logic         resetn_i = 1'b1;
  logic         cacheMiss_i = 1'b0;
  logic [63:0]  missedAddress_i = '0;
  logic [19:0]  missedPid_i = '0;
  logic [15:0]  missedTid_i = '0;
  logic         flush_i = 1'b0;
  logic         memReqValid_o;
  logic         memReqReady_i = 1'b0;
  logic [63:0]  memReqAddress_o;
  logic         memRespValid_i = 1'b0;
  logic [255:0] memRespData_i = '0;
  logic         memRespError_i = 1'b0;
  logic         cacheUpdate_o;
  logic [63:0]  cacheUpdateAddress_o;
  logic [511:0] cacheUpdateLine1_o;
  logic [511:0] cacheUpdateLine2_o;
  logic [19:0]  cacheUpdatePid_o;
  logic [15:0]  cacheUpdateTid_o;
  logic         missQueueFull_o;
  logic         refillError_o;
  logic         busy_o;

  l1i_refill_controller #(
    .fetchingAddressWidth (64),
    .cacheLineWidth       (512),
    .memBeatWidth         (256),
    .PidSize              (20),
    .TidSize              (16),
    .missQueueDepth       (2)
  ) dut (
    .clock_i              (clock_i),
    .resetn_i             (resetn_i),
    .cacheMiss_i          (cacheMiss_i),
    .missedAddress_i      (missedAddress_i),
    .missedPid_i          (missedPid_i),
    .missedTid_i          (missedTid_i),
    .flush_i              (flush_i),
    .memReqValid_o        (memReqValid_o),
    .memReqReady_i        (memReqReady_i),
    .memReqAddress_o      (memReqAddress_o),
    .memRespValid_i       (memRespValid_i),
    .memRespData_i        (memRespData_i),
    .memRespError_i       (memRespError_i),
    .cacheUpdate_o        (cacheUpdate_o),
    .cacheUpdateAddress_o (cacheUpdateAddress_o),
    .cacheUpdateLine1_o   (cacheUpdateLine1_o),
    .cacheUpdateLine2_o   (cacheUpdateLine2_o),
    .cacheUpdatePid_o     (cacheUpdatePid_o),
    .cacheUpdateTid_o     (cacheUpdateTid_o),
    .missQueueFull_o      (missQueueFull_o),
    .refillError_o        (refillError_o),
    .busy_o               (busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [63:0]  address;
    logic [511:0] line1;
    logic [511:0] line2;
    logic [19:0]  pid;
    logic [15:0]  tid;
    logic         isError;
  } updateExp_t;

  logic [63:0] expReqQ[$];
  updateExp_t  expUpdQ[$];
  int vectorCount = 0;
  int missCount = 0;

  localparam logic [255:0] beatA = {64{4'hA}};
  localparam logic [255:0] beatB = {64{4'hB}};
  localparam logic [255:0] beatC = {64{4'hC}};
  localparam logic [255:0] beatD = {64{4'hD}};

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0b, required %0b", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input logic [19:0] pid, input logic [15:0] tid);
    cacheMiss_i     = 1'b1;
    missedAddress_i = addr;
    missedPid_i     = pid;
    missedTid_i     = tid;
    tick();
    cacheMiss_i     = 1'b0;
  endtask

  task automatic expectRefill(input logic [63:0] blockAddr, input logic [19:0] pid, input logic [15:0] tid,
                              input logic [255:0] b0, input logic [255:0] b1,
                              input logic [255:0] b2, input logic [255:0] b3, input logic isError);
    updateExp_t e;
    e.address = blockAddr;
    e.line1   = {b1, b0};
    e.line2   = {b3, b2};
    e.pid     = pid;
    e.tid     = tid;
    e.isError = isError;
    expReqQ.push_back(blockAddr);
    expUpdQ.push_back(e);
  endtask

  // Returns one cycle after the request handshake edge, i.e. in FILL.
  task automatic waitForRequest();
    int n;
    n = 0;
    while (!(memReqValid_o && memReqReady_i) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL requestTimeout: got no handshake in %0d cycles, required one", n);
    end
    tick();
  endtask

  task automatic sendBeats(input logic [255:0] b0, input logic [255:0] b1, input logic [255:0] b2,
                           input logic [255:0] b3, input int errBeat, input int flushBeat);
    logic [255:0] beats [4];
    beats[0] = b0;
    beats[1] = b1;
    beats[2] = b2;
    beats[3] = b3;
    for (int i = 0; i < 4; i++) begin
      memRespValid_i = 1'b1;
      memRespData_i  = beats[i];
      memRespError_i = (i == errBeat);
      flush_i        = (i == flushBeat);
      tick();
    end
    memRespValid_i = 1'b0;
    memRespError_i = 1'b0;
    flush_i        = 1'b0;
    memRespData_i  = '0;
  endtask

  // Monitor: every request handshake and every update/error pulse pops the scoreboard.
  always @(negedge clock_i) begin : monitor
    logic [63:0] expAddr;
    updateExp_t  e;
    if (resetn_i) begin
      if (memReqValid_o && memReqReady_i) begin
        if (expReqQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL unexpectedRequest: got request %0h, required none", memReqAddress_o);
        end else begin
          expAddr = expReqQ.pop_front();
          checkOutput("memReqAddress", 512'(memReqAddress_o), 512'(expAddr));
        end
      end
      if (cacheUpdate_o || refillError_o) begin
        if (expUpdQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL unexpectedUpdate: got update=%0b error=%0b, required none",
                   cacheUpdate_o, refillError_o);
        end else begin
          e = expUpdQ.pop_front();
          checkFlag("cacheUpdate", cacheUpdate_o, !e.isError);
          checkFlag("refillError", refillError_o, e.isError);
          if (!e.isError) begin
            checkOutput("updateAddress", 512'(cacheUpdateAddress_o), 512'(e.address));
            checkOutput("updateLine1", cacheUpdateLine1_o, e.line1);
            checkOutput("updateLine2", cacheUpdateLine2_o, e.line2);
            checkOutput("updatePid", 512'(cacheUpdatePid_o), 512'(e.pid));
            checkOutput("updateTid", 512'(cacheUpdateTid_o), 512'(e.tid));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no end of run, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 resetn_i = 1'b0;
    #2;
    checkFlag("resetMemReqValid", memReqValid_o, 1'b0);
    checkFlag("resetCacheUpdate", cacheUpdate_o, 1'b0);
    checkFlag("resetRefillError", refillError_o, 1'b0);
    checkFlag("resetBusy", busy_o, 1'b0);
    checkFlag("resetQueueFull", missQueueFull_o, 1'b0);
    checkOutput("resetMemReqAddress", 512'(memReqAddress_o), 512'(0));
    repeat (3) @(posedge clock_i);
    #1 resetn_i = 1'b1;
    tick();

    $display("[TB] basic refill of 0x1044");
    memReqReady_i = 1'b1;
    expectRefill(64'h1000, 20'd3, 16'd7, beatA, beatB, beatC, beatD, 1'b0);
    applyStimulus(64'h1044, 20'd3, 16'd7);
    checkFlag("reqLatencyN1", memReqValid_o, 1'b0);
    tick();
    checkFlag("reqLatencyN2", memReqValid_o, 1'b1);
    waitForRequest();
    sendBeats(beatA, beatB, beatC, beatD, -1, -1);
    checkFlag("updateLatency", cacheUpdate_o, 1'b1);
    tick();
    checkFlag("updateOneCycle", cacheUpdate_o, 1'b0);
    checkFlag("idleAfterUpdate", busy_o, 1'b0);

    $display("[TB] duplicate block 0x2000/0x2040");
    expectRefill(64'h2000, 20'd5, 16'd1, beatD, beatC, beatB, beatA, 1'b0);
    applyStimulus(64'h2000, 20'd5, 16'd1);
    applyStimulus(64'h2040, 20'd5, 16'd2);
    waitForRequest();
    sendBeats(beatD, beatC, beatB, beatA, -1, -1);
    tick();
    repeat (3) tick();
    checkFlag("dupNoSecondReq", memReqValid_o, 1'b0);
    checkFlag("dupIdle", busy_o, 1'b0);

    $display("[TB] queue fills during stalled request");
    memReqReady_i = 1'b0;
    expectRefill(64'h4000, 20'd1, 16'd4, beatA, beatA, beatB, beatB, 1'b0);
    expectRefill(64'h5000, 20'd1, 16'd5, beatC, beatC, beatD, beatD, 1'b0);
    expectRefill(64'h6000, 20'd1, 16'd6, beatB, beatA, beatD, beatC, 1'b0);
    applyStimulus(64'h4000, 20'd1, 16'd4);
    applyStimulus(64'h5010, 20'd1, 16'd5);
    applyStimulus(64'h6020, 20'd1, 16'd6);
    applyStimulus(64'h7030, 20'd1, 16'd7);
    checkFlag("queueFull", missQueueFull_o, 1'b1);
    checkFlag("stalledReqValid", memReqValid_o, 1'b1);
    memReqReady_i = 1'b1;
    waitForRequest();
    sendBeats(beatA, beatA, beatB, beatB, -1, -1);
    waitForRequest();
    checkFlag("queueNotFull", missQueueFull_o, 1'b0);
    sendBeats(beatC, beatC, beatD, beatD, -1, -1);
    waitForRequest();
    sendBeats(beatB, beatA, beatD, beatC, -1, -1);
    tick();
    checkFlag("thirdMissIgnored", busy_o, 1'b0);

    $display("[TB] error on beat 2");
    expectRefill(64'h3000, 20'd2, 16'd9, beatA, beatB, beatC, beatD, 1'b1);
    expectRefill(64'h8000, 20'd2, 16'd8, beatC, beatD, beatA, beatB, 1'b0);
    applyStimulus(64'h3000, 20'd2, 16'd9);
    applyStimulus(64'h8000, 20'd2, 16'd8);
    waitForRequest();
    sendBeats(beatA, beatB, beatC, beatD, 2, -1);
    checkFlag("errorPulse", refillError_o, 1'b1);
    checkFlag("errorNoUpdate", cacheUpdate_o, 1'b0);
    tick();
    checkFlag("errorPulseEnds", refillError_o, 1'b0);
    waitForRequest();
    sendBeats(beatC, beatD, beatA, beatB, -1, -1);
    checkFlag("afterErrorUpdate", cacheUpdate_o, 1'b1);
    tick();

    $display("[TB] flush during fill");
    memReqReady_i = 1'b0;
    expectRefill(64'h9000, 20'd4, 16'd3, beatD, beatA, beatC, beatB, 1'b0);
    applyStimulus(64'h9000, 20'd4, 16'd3);
    applyStimulus(64'hA000, 20'd4, 16'd3);
    applyStimulus(64'hB000, 20'd4, 16'd3);
    checkFlag("flushQueueFull", missQueueFull_o, 1'b1);
    memReqReady_i = 1'b1;
    waitForRequest();
    sendBeats(beatD, beatA, beatC, beatB, -1, 1);
    checkFlag("flushRefillUpdates", cacheUpdate_o, 1'b1);
    checkFlag("flushClearsFull", missQueueFull_o, 1'b0);
    tick();
    checkFlag("flushBusyLow", busy_o, 1'b0);
    repeat (3) tick();
    checkFlag("flushNoRequest", memReqValid_o, 1'b0);

    $display("[TB] reset mid-refill");
    expReqQ.push_back(64'hC000);
    applyStimulus(64'hC000, 20'd6, 16'd2);
    waitForRequest();
    memRespValid_i = 1'b1;
    memRespData_i  = beatB;
    tick();
    memRespData_i  = beatC;
    tick();
    memRespData_i  = beatD;
    resetn_i = 1'b0;
    #1;
    checkFlag("midResetReqValid", memReqValid_o, 1'b0);
    checkFlag("midResetBusy", busy_o, 1'b0);
    checkFlag("midResetUpdate", cacheUpdate_o, 1'b0);
    checkOutput("midResetLine1", cacheUpdateLine1_o, 512'(0));
    tick();
    resetn_i = 1'b1;
    memRespData_i = beatA;
    tick();
    memRespValid_i = 1'b0;
    repeat (4) tick();
    checkFlag("postResetNoUpdate", cacheUpdate_o, 1'b0);
    checkFlag("postResetIdle", busy_o, 1'b0);
    checkOutput("postResetLine1", cacheUpdateLine1_o, 512'(0));

    checkOutput("pendingRequests", 512'(expReqQ.size()), 512'(0));
    checkOutput("pendingUpdates", 512'(expUpdQ.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/l1i_refill_controller.md
L1I_REFILL_CONTROLLER -- requirements
Module: l1i_refill_controller

Interface
REQ-001 SHALL have parameters: fetchingAddressWidth, default 64, address width; cacheLineWidth, default 512, one cache line; memBeatWidth, default 256, memory response beat; PidSize, default 20; TidSize, default 16; missQueueDepth, default 2, pending-miss FIFO entries.
REQ-002 SHALL have one clock; reset is asynchronous and active-low: clock_i input 1, rising-edge clock for all state; resetn_i input 1, async active-low reset.
REQ-003 cacheMiss_i input 1, miss pulse from L1I; missedAddress_i input 64; missedPid_i input PidSize; missedTid_i input TidSize.
REQ-004 flush_i input 1, drop all queued, not-yet-requested misses.
REQ-005 memReqValid_o output 1; memReqReady_i input 1; memReqAddress_o output 64, 128-byte-aligned block address.
REQ-006 memRespValid_i input 1; memRespData_i input memBeatWidth; memRespError_i input 1, per-beat error flag.
REQ-007 cacheUpdate_o output 1; cacheUpdateAddress_o output 64; cacheUpdateLine1_o and cacheUpdateLine2_o output cacheLineWidth each; cacheUpdatePid_o output PidSize; cacheUpdateTid_o output TidSize.
REQ-008 missQueueFull_o output 1, fetch must stall; refillError_o output 1, one-cycle pulse; busy_o output 1, FSM not IDLE or queue non-empty.

Function
REQ-009 Block address SHALL be missedAddress_i with bits [6:0] cleared; one refill covers two consecutive 64-byte lines.
REQ-010 Miss SHALL be enqueued when cacheMiss_i=1, not a duplicate, and occupancy < missQueueDepth or a pop occurs the same cycle.
REQ-011 Duplicate = same block address and Pid as any queue entry or the in-flight refill; duplicates SHALL be dropped silently.
REQ-012 Non-duplicate miss arriving while full with no same-cycle pop SHALL be ignored; missQueueFull_o = (occupancy == missQueueDepth), registered.
REQ-013 FSM states SHALL be IDLE, REQ, FILL, UPDATE.
REQ-014 IDLE->REQ when queue non-empty: pop head into in-flight registers; memReqValid_o=1 from the next cycle.
REQ-015 In REQ, memReqValid_o and memReqAddress_o SHALL hold until memReqReady_i=1; then ->FILL with beat counter 0.
REQ-016 In FILL, each cycle with memRespValid_i=1 SHALL accept one beat in order: beats 0,1 -> Line1 bits [0:255],[256:511]; beats 2,3 -> Line2 likewise; after beat 3 ->UPDATE.
REQ-017 Beats outside FILL SHALL be ignored; the 2-bit beat counter SHALL wrap to 0 on leaving FILL.
REQ-018 Any beat with memRespError_i=1 SHALL set a sticky error flag; remaining beats are still consumed.
REQ-019 UPDATE lasts exactly one cycle: no error -> cacheUpdate_o=1 with address, lines, Pid, Tid valid; error -> cacheUpdate_o=0, refillError_o=1; then ->IDLE.
REQ-020 Latency: miss at empty IDLE in cycle N -> memReqValid_o at N+2; last beat in cycle M -> cacheUpdate_o at M+1.
REQ-021 flush_i SHALL clear queue occupancy next cycle; in-flight refill completes normally; a miss coincident with flush_i is dropped.
REQ-022 Outputs other than in REQ-015/REQ-019 SHALL be registered and 0 when not asserted (lines/address may hold stale data).

Reset
REQ-023 resetn_i=0 SHALL asynchronously force IDLE, occupancy 0, beat counter 0, error flag 0, and all outputs 0.
REQ-024 Reset mid-refill SHALL abandon it; no cacheUpdate_o afterwards for that block.

Structure
REQ-025 Shared package l1i_pkg SHALL hold width defaults, refill beat count (4), block-offset width (7) and the FSM state enum.
REQ-026 Queue SHALL be sub-module l1i_miss_queue (FIFO of {block address, Pid, Tid} with duplicate-match output).

Verification
REQ-027 Miss addr 0x1044, Pid 3; ready=1; beats 0xA..,0xB..,0xC..,0xD.. -> memReqAddress_o 0x1000; cacheUpdate_o one cycle, Line1={A,B}, Line2={C,D}, Pid 3.
REQ-028 Misses 0x2000 then 0x2040, same Pid -> one memory request only.
REQ-029 Three distinct misses during a stalled refill (ready=0) -> two queued, missQueueFull_o=1, third ignored; requests issued in order.
REQ-030 Error on beat 2 of 0x3000 -> refillError_o pulse, cacheUpdate_o stays 0, next queued miss proceeds.
REQ-031 flush_i with two queued entries during FILL -> current refill updates; no further requests; busy_o=0 after UPDATE.
REQ-032 resetn_i low after beat 1 -> outputs 0 immediately; later beats ignored; no update.
